// File: rtl/psdsqrt.sv
// rtl/psdsqrt.sv - bit-serial floor(sqrt(xin)), one root bit per clock, MSB first
module psdsqrt #(
    parameter int NBITSIN = 32,
    parameter int k       = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NBITSIN+k-1:0]           xin,
    output logic [(NBITSIN+k)/2-1:0]       sqrt
);
    localparam int N = NBITSIN + k;
    localparam int W = N / 2;

    logic [N-1:0] x_q, x_d;
    logic [W-1:0] root_q, root_d;
    logic [W-1:0] mask_q, mask_d;
    logic         busy_q, busy_d;
    logic [W-1:0] sqrt_q, sqrt_d;

    logic [W-1:0] trial;
    logic [N-1:0] trial_sq;

    // Square is taken at the full 2W operand width, so it can never overflow.
    assign trial    = root_q | mask_q;
    assign trial_sq = {{W{1'b0}}, trial} * {{W{1'b0}}, trial};
    assign sqrt     = sqrt_q;

    always_comb begin
        x_d    = x_q;
        root_d = root_q;
        mask_d = mask_q;
        busy_d = busy_q;
        sqrt_d = sqrt_q;

        // Output samples the root as it stood before this edge's update.
        if (stop) begin
            sqrt_d = root_q;
        end

        if (start) begin
            x_d    = xin;
            root_d = '0;
            mask_d = {1'b1, {(W-1){1'b0}}};
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (x_q >= trial_sq) begin
                root_d = trial;
            end
            mask_d = mask_q >> 1;
            busy_d = |mask_q[W-1:1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            root_q <= '0;
            mask_q <= '0;
            busy_q <= 1'b0;
            sqrt_q <= '0;
        end else begin
            x_q    <= x_d;
            root_q <= root_d;
            mask_q <= mask_d;
            busy_q <= busy_d;
            sqrt_q <= sqrt_d;
        end
    end

endmodule

// File: tb/tb_psdsqrt.sv
// tb/tb_psdsqrt.sv - directed and reference-model checks for psdsqrt
module tb_psdsqrt;
    localparam int NBITSIN = 32;
    localparam int K       = 20;
    localparam int N       = NBITSIN + K;
    localparam int W       = N / 2;
    localparam int NRAND   = 1000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic [N-1:0] xin   = '0;
    logic [W-1:0] sqrt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    psdsqrt #(.NBITSIN(NBITSIN), .k(K)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stop (stop),
        .xin  (xin),
        .sqrt (sqrt)
    );

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r;
        r = longint'($rtoi($sqrt(real'(x))));
        while (r * r > x) r = r - 1;
        while ((r + 1) * (r + 1) <= x) r = r + 1;
        return r;
    endfunction

    // Called at posedge+1; the next posedge is the start edge.
    task automatic launch(input logic [N-1:0] x);
        xin   = x;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Stop is sampled on the n-th posedge after the start edge.
    task automatic stop_after(input int n);
        repeat (n - 1) @(posedge clock);
        #1;
        stop = 1'b1;
        @(posedge clock);
        #1;
        stop = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (sqrt !== '0) begin
            errors++;
            $display("FAIL reset_value got %0d expected 0", sqrt);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        stop_after(1);
        checks++;
        if (sqrt !== '0) begin
            errors++;
            $display("FAIL stop_after_reset got %0d expected 0", sqrt);
        end
    endtask

    task automatic test_directed;
        logic [N-1:0] xs [8];
        logic [W-1:0] es [8];
        xs[0] = N'(123456);          es[0] = W'(351);
        xs[1] = '0;                  es[1] = '0;
        xs[2] = {N{1'b1}};           es[2] = W'(67108863);
        xs[3] = N'(144);             es[3] = W'(12);
        xs[4] = N'(143);             es[4] = W'(11);
        xs[5] = N'(1);               es[5] = W'(1);
        xs[6] = N'(2) << 20;         es[6] = W'(1448);
        xs[7] = N'(10000);           es[7] = W'(100);
        for (int i = 0; i < 8; i++) begin
            launch(xs[i]);
            stop_after(W + 1);
            checks++;
            if (sqrt !== es[i]) begin
                errors++;
                $display("FAIL directed_%0d xin=%0d got %0d expected %0d", i, xs[i], sqrt, es[i]);
            end
        end
    endtask

    task automatic test_early_stop;
        launch(N'(1) << 51);
        stop_after(2);
        checks++;
        if (sqrt !== (W'(1) << 25)) begin
            errors++;
            $display("FAIL early_stop_pow2 got %0d expected %0d", sqrt, W'(1) << 25);
        end
        launch((N'(1) << 51) | (N'(1) << 40));
        stop_after(2);
        checks++;
        if (sqrt !== (W'(1) << 25)) begin
            errors++;
            $display("FAIL early_stop_partial got %0d expected %0d", sqrt, W'(1) << 25);
        end
        repeat (W + 2) @(posedge clock);
        #1;
        checks++;
        if (sqrt !== (W'(1) << 25)) begin
            errors++;
            $display("FAIL sqrt_hold_without_stop got %0d expected %0d", sqrt, W'(1) << 25);
        end
    endtask

    task automatic test_xin_ignored;
        launch(N'(10000));
        xin = N'(5);
        stop_after(W + 1);
        checks++;
        if (sqrt !== W'(100)) begin
            errors++;
            $display("FAIL xin_ignored got %0d expected 100", sqrt);
        end
    endtask

    task automatic test_reset_mid;
        launch(N'(123456));
        stop_after(W + 1);
        launch(N'(10000));
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (sqrt !== '0) begin
            errors++;
            $display("FAIL async_reset got %0d expected 0", sqrt);
        end
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        stop_after(1);
        checks++;
        if (sqrt !== '0) begin
            errors++;
            $display("FAIL stop_after_mid_reset got %0d expected 0", sqrt);
        end
    endtask

    task automatic test_restart;
        launch(N'(100));
        repeat (2) @(posedge clock);
        #1;
        launch(N'(10000));
        stop_after(W + 1);
        checks++;
        if (sqrt !== W'(100)) begin
            errors++;
            $display("FAIL restart got %0d expected 100", sqrt);
        end
    endtask

    task automatic test_start_stop_same;
        launch(N'(144));
        stop_after(W + 1);
        xin   = N'(1) << 50;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (sqrt !== W'(12)) begin
            errors++;
            $display("FAIL start_stop_same_old got %0d expected 12", sqrt);
        end
        stop_after(W + 1);
        checks++;
        if (sqrt !== (W'(1) << 25)) begin
            errors++;
            $display("FAIL start_stop_same_new got %0d expected %0d", sqrt, W'(1) << 25);
        end
    endtask

    // Back-to-back: each stop shares its edge with the next start.
    task automatic test_back_to_back;
        logic [63:0]     rnd;
        logic [N-1:0]    x;
        longint unsigned ref_root;
        logic [W-1:0]    exp_prev;
        rnd = {$urandom(), $urandom()};
        x   = rnd[N-1:0];
        launch(x);
        ref_root = isqrt(64'(x));
        exp_prev = ref_root[W-1:0];
        for (int i = 0; i < NRAND; i++) begin
            rnd = {$urandom(), $urandom()};
            x   = rnd[N-1:0] >> $urandom_range(0, N - 1);
            repeat (W) @(posedge clock);
            #1;
            xin   = x;
            start = 1'b1;
            stop  = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            checks++;
            if (sqrt !== exp_prev) begin
                errors++;
                $display("FAIL random_%0d got %0d expected %0d", i, sqrt, exp_prev);
            end
            ref_root = isqrt(64'(x));
            exp_prev = ref_root[W-1:0];
        end
        stop_after(W + 1);
        checks++;
        if (sqrt !== exp_prev) begin
            errors++;
            $display("FAIL random_last got %0d expected %0d", sqrt, exp_prev);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_early_stop;
        test_xin_ignored;
        test_reset_mid;
        test_restart;
        test_start_stop_same;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
